// File: rtl/alu_arbiter.sv
// Purpose : round-robin sharing of one combinational ALU between two valid/ready requesters.
// Latency : 2 cycles accept->response (issue reg, then response reg); 1 op/cycle throughput.
// Backpressure: rsp_ready=0 stalls the response then the issue register; both req_ready drop when full.
//
// Ports: clk/rst_n (async active-low); req0_*/req1_* request channels (valid, ready, a, b,
// sel, op); alu_a/alu_b/alu_sel/alu_op registered ALU inputs; alu_result/carry/zero/sign
// from the ALU; rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_carry/rsp_zero/rsp_sign response.
// Optional: define ALU_ARB_LOCK_EN to add req0_lock/req1_lock (sticky grant for op sequences).
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sel,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sel,
  input  logic [OPW-1:0]   req1_op,
`ifdef ALU_ARB_LOCK_EN
  input  logic             req0_lock,
  input  logic             req1_lock,
`endif
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sel,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_sign,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_sign
);

  logic             issue_valid_q, issue_valid_d;
  logic             issue_id_q, issue_id_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic             alu_sel_q, alu_sel_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d, rsp_zero_q, rsp_zero_d, rsp_sign_q, rsp_sign_d;

  logic rsp_free, issue_adv, can_accept, accept, pref, grant_id;
`ifdef ALU_ARB_LOCK_EN
  logic lock_q, lock_d, lock_id_q, lock_id_d, grant_lock, locked_valid, other_valid;
`endif

  always_comb begin
    rsp_free   = !rsp_valid_q | rsp_ready;
    issue_adv  = issue_valid_q & rsp_free;
    can_accept = !issue_valid_q | issue_adv;

`ifdef ALU_ARB_LOCK_EN
    pref = lock_q ? lock_id_q : rr_ptr_q;
`else
    pref = rr_ptr_q;
`endif
    // With a single requester, grant_id simply follows req1_valid.
    grant_id = (req0_valid & req1_valid) ? pref : req1_valid;
    // rst_n gating keeps both readies low while reset is asserted.
    accept     = can_accept & (req0_valid | req1_valid) & rst_n;
    req0_ready = accept & !grant_id;
    req1_ready = accept & grant_id;

    issue_valid_d = issue_valid_q;
    issue_id_d    = issue_id_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_sel_d     = alu_sel_q;
    alu_op_d      = alu_op_q;
    rr_ptr_d      = rr_ptr_q;
    if (accept) begin
      issue_valid_d = 1'b1;
      issue_id_d    = grant_id;
      alu_a_d       = grant_id ? req1_a   : req0_a;
      alu_b_d       = grant_id ? req1_b   : req0_b;
      alu_sel_d     = grant_id ? req1_sel : req0_sel;
      alu_op_d      = grant_id ? req1_op  : req0_op;
    end else if (issue_adv) begin
      // Operands are left as-is; only the valid bit drops.
      issue_valid_d = 1'b0;
    end

`ifdef ALU_ARB_LOCK_EN
    grant_lock   = grant_id ? req1_lock : req0_lock;
    locked_valid = lock_id_q ? req1_valid : req0_valid;
    other_valid  = lock_id_q ? req0_valid : req1_valid;
    lock_d       = lock_q;
    lock_id_d    = lock_id_q;
    if (accept) begin
      lock_d    = grant_lock;
      lock_id_d = grant_id;
      // A locked sequence does not advance the round-robin pointer.
      if (!grant_lock) rr_ptr_d = ~grant_id;
    end else if (lock_q & !locked_valid & other_valid) begin
      lock_d = 1'b0;
    end
`else
    if (accept) rr_ptr_d = ~grant_id;
`endif

    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_sign_d   = rsp_sign_q;
    if (issue_adv) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = issue_id_q;
      rsp_result_d = alu_result;
      rsp_carry_d  = alu_carry;
      rsp_zero_d   = alu_zero;
      rsp_sign_d   = alu_sign;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      issue_id_q    <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_sel_q     <= 1'b0;
      alu_op_q      <= '0;
      rr_ptr_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= '0;
      rsp_carry_q   <= 1'b0;
      rsp_zero_q    <= 1'b0;
      rsp_sign_q    <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      lock_q        <= 1'b0;
      lock_id_q     <= 1'b0;
`endif
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_id_q    <= issue_id_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_sel_q     <= alu_sel_d;
      alu_op_q      <= alu_op_d;
      rr_ptr_q      <= rr_ptr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result_q  <= rsp_result_d;
      rsp_carry_q   <= rsp_carry_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_sign_q    <= rsp_sign_d;
`ifdef ALU_ARB_LOCK_EN
      lock_q        <= lock_d;
      lock_id_q     <= lock_id_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_sign   = rsp_sign_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU drives the result/flags, requests are queued per
// port and expected responses are pushed to a scoreboard at each accept, popped at each
// response handshake. Each task below exercises one scenario with inline checks.
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int OW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req0_valid, req0_ready, req0_sel, req1_valid, req1_ready, req1_sel;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [OW-1:0] req0_op, req1_op;
  logic          req0_lock, req1_lock;
  logic [W-1:0]  alu_a, alu_b, alu_result, rsp_result;
  logic          alu_sel, alu_carry, alu_zero, alu_sign;
  logic [OW-1:0] alu_op;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, rsp_sign;

  alu_arbiter #(.WIDTH(W), .OPW(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .req1_op(req1_op),
`ifdef ALU_ARB_LOCK_EN
    .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign)
  );

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sel;
    logic [OW-1:0] op;
    logic          lock;
  } req_t;

  typedef struct packed {
    logic         id;
    logic         c;
    logic         z;
    logic         s;
    logic [W-1:0] r;
  } exp_t;

  // Behavioural ALU: {carry, zero, sign, result}.
  function automatic logic [W+2:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sel, input logic [OW-1:0] op);
    logic [W:0] s;
    if (sel) s = {1'b0, a} - {1'b0, b};
    else begin
      case (op[2:0])
        3'd0:    s = {1'b0, a & b};
        3'd1:    s = {1'b0, a | b};
        3'd2:    s = {1'b0, a ^ b};
        3'd3:    s = {1'b0, a} - {1'b0, b};
        default: s = {1'b0, a} + {1'b0, b};
      endcase
    end
    return {s[W], s[W-1:0] == '0, s[W-1], s[W-1:0]};
  endfunction

  assign {alu_carry, alu_zero, alu_sign, alu_result} = alu_f(alu_a, alu_b, alu_sel, alu_op);

  function automatic exp_t mk_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sel, input logic [OW-1:0] op);
    return exp_t'({id, alu_f(a, b, sel, op)});
  endfunction

  function automatic req_t mk_req(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sel, input logic [OW-1:0] op, input logic lock);
    return '{a: a, b: b, sel: sel, op: op, lock: lock};
  endfunction

  int   n_checks = 0;
  int   n_errors = 0;
  req_t pend0[$], pend1[$];
  exp_t sb[$];
  int   grant_log[$], rsp_log[$];
  logic acc0 = 1'b0, acc1 = 1'b0;
  exp_t e_mon;

  // Accept/response monitor, sampled on the falling edge (mid-cycle).
  always @(negedge clk) begin
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst_n) begin
      if (req0_valid && req0_ready) begin
        acc0 = 1'b1;
        grant_log.push_back(0);
        sb.push_back(mk_exp(1'b0, req0_a, req0_b, req0_sel, req0_op));
      end
      if (req1_valid && req1_ready) begin
        acc1 = 1'b1;
        grant_log.push_back(1);
        sb.push_back(mk_exp(1'b1, req1_a, req1_b, req1_sel, req1_op));
      end
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL rsp_unexpected: got id=%0d result=%h, required no response", rsp_id, rsp_result);
        end else begin
          e_mon = sb.pop_front();
          if ({rsp_id, rsp_carry, rsp_zero, rsp_sign, rsp_result} !== e_mon) begin
            n_errors++;
            $display("FAIL rsp_data: got id=%0d c=%b z=%b s=%b r=%h, required id=%0d c=%b z=%b s=%b r=%h",
                     rsp_id, rsp_carry, rsp_zero, rsp_sign, rsp_result,
                     e_mon.id, e_mon.c, e_mon.z, e_mon.s, e_mon.r);
          end
        end
        rsp_log.push_back(int'(rsp_id));
      end
    end
  end

  task automatic apply();
    req0_valid = (pend0.size() != 0);
    req1_valid = (pend1.size() != 0);
    if (req0_valid) begin
      req0_a = pend0[0].a; req0_b = pend0[0].b; req0_sel = pend0[0].sel;
      req0_op = pend0[0].op; req0_lock = pend0[0].lock;
    end
    if (req1_valid) begin
      req1_a = pend1[0].a; req1_b = pend1[0].b; req1_sel = pend1[0].sel;
      req1_op = pend1[0].op; req1_lock = pend1[0].lock;
    end
  endtask

  // Advance one clock; requests are retired only when the monitor saw them accepted.
  task automatic step();
    @(posedge clk);
    #1;
    if (acc0) pend0.delete(0);
    if (acc1) pend1.delete(0);
    apply();
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    rsp_ready = 1'b1;
    while ((pend0.size() != 0 || pend1.size() != 0 || sb.size() != 0 || rsp_valid) && cyc < 200) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc >= 200) begin
      n_errors++;
      $display("FAIL %s drain_timeout: %0d ops outstanding after %0d cycles, required 0", name, sb.size(), cyc);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    pend0.delete(); pend1.delete(); sb.delete();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;   // readies must stay low anyway
    req0_a = '0; req0_b = '0; req0_sel = 1'b0; req0_op = '0; req0_lock = 1'b0;
    req1_a = '0; req1_b = '0; req1_sel = 1'b0; req1_op = '0; req1_lock = 1'b0;
    #3;
    n_checks++;
    if ({alu_a, alu_b, alu_sel, alu_op} !== '0) begin
      n_errors++; $display("FAIL reset_alu: got %h/%h/%b/%h, required all 0", alu_a, alu_b, alu_sel, alu_op);
    end
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_sign, rsp_result} !== '0) begin
      n_errors++; $display("FAIL reset_rsp: got v=%b id=%b r=%h, required all 0", rsp_valid, rsp_id, rsp_result);
    end
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_errors++; $display("FAIL reset_ready: got %b%b, required 00", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_idle_rsp: got %b, required 0", rsp_valid);
    end
    step();
  endtask

  task automatic test_single_op();
    logic [W+2:0] snap;
    rsp_ready = 1'b1;
    pend0.push_back(mk_req(32'hFFFC1FFF, 32'h00000007, 1'b0, 5'b00101, 1'b0));
    apply();
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_errors++; $display("FAIL single_ready: got %b, required 1", req0_ready);
    end
    step();
    @(negedge clk);
    n_checks++;
    if ({alu_a, alu_b, alu_sel, alu_op} !== {32'hFFFC1FFF, 32'h00000007, 1'b0, 5'b00101}) begin
      n_errors++; $display("FAIL single_issue: got a=%h b=%h sel=%b op=%h, required FFFC1FFF/00000007/0/05",
                           alu_a, alu_b, alu_sel, alu_op);
    end
    snap = {alu_carry, alu_zero, alu_sign, alu_result};
    step();
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_id} !== 2'b10) begin
      n_errors++; $display("FAIL single_rsp_vld: got v=%b id=%b, required v=1 id=0", rsp_valid, rsp_id);
    end
    n_checks++;
    if ({rsp_carry, rsp_zero, rsp_sign, rsp_result} !== snap) begin
      n_errors++; $display("FAIL single_rsp_snap: got %h, required %h", {rsp_carry, rsp_zero, rsp_sign, rsp_result}, snap);
    end
    n_checks++;
    if ({rsp_carry, rsp_zero, rsp_sign, rsp_result} !== {3'b001, 32'hFFFC2006}) begin
      n_errors++; $display("FAIL single_rsp_const: got %h, required 1fffc2006", {rsp_carry, rsp_zero, rsp_sign, rsp_result});
    end
    drain("single");
  endtask

  task automatic test_conflict();
    do_reset();
    grant_log.delete(); rsp_log.delete();
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pend0.push_back(mk_req($urandom, $urandom, 1'b0, OW'(k), 1'b0));
      pend1.push_back(mk_req($urandom, $urandom, k[0], OW'(4 + k), 1'b0));
    end
    apply();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) begin
        n_checks++;
        if ((req0_ready ^ req1_ready) !== 1'b1) begin
          n_errors++; $display("FAIL conflict_one_ready cyc %0d: got %b%b, required exactly one", k, req0_ready, req1_ready);
        end
      end
      if (k >= 2) begin
        n_checks++;
        if (rsp_valid !== 1'b1) begin
          n_errors++; $display("FAIL conflict_rsp_rate cyc %0d: got rsp_valid=%b, required 1", k, rsp_valid);
        end
      end
      step();
    end
    drain("conflict");
    n_checks++;
    if (grant_log.size() != 8 || rsp_log.size() != 8) begin
      n_errors++; $display("FAIL conflict_count: got %0d grants %0d rsps, required 8 and 8", grant_log.size(), rsp_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (grant_log[i] != (i % 2) || rsp_log[i] != (i % 2)) begin
          n_errors++; $display("FAIL conflict_order[%0d]: got grant %0d rsp %0d, required %0d", i, grant_log[i], rsp_log[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2*W+OW:0] snap_alu;
    logic [W+4:0]    snap_rsp;
    grant_log.delete(); rsp_log.delete();
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) pend1.push_back(mk_req($urandom, $urandom, k[1], OW'(k + 2), 1'b0));
    apply();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (req1_ready !== (k < 2)) begin
        n_errors++; $display("FAIL bp_ready cyc %0d: got %b, required %b", k, req1_ready, k < 2);
      end
      if (k == 2) begin
        snap_alu = {alu_a, alu_b, alu_sel, alu_op};
        snap_rsp = {rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_sign, rsp_result};
        n_checks++;
        if (rsp_valid !== 1'b1) begin
          n_errors++; $display("FAIL bp_rsp_vld: got %b, required 1", rsp_valid);
        end
      end
      if (k > 2) begin
        n_checks++;
        if ({alu_a, alu_b, alu_sel, alu_op} !== snap_alu ||
            {rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_sign, rsp_result} !== snap_rsp) begin
          n_errors++; $display("FAIL bp_stable cyc %0d: got alu %h rsp %h, required alu %h rsp %h", k,
                               {alu_a, alu_b, alu_sel, alu_op}, {rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_sign, rsp_result},
                               snap_alu, snap_rsp);
        end
      end
      if (k == 4) begin
        n_checks++;
        if (grant_log.size() != 2) begin
          n_errors++; $display("FAIL bp_accepts: got %0d, required 2", grant_log.size());
        end
      end
      step();
    end
    drain("backpressure");
    n_checks++;
    if (rsp_log.size() != 4 || rsp_log.sum() != 4) begin
      n_errors++; $display("FAIL bp_rsp_count: got %0d responses, required 4 all from port 1", rsp_log.size());
    end
  endtask

  task automatic test_drain_refill();
    req_t o0, o1;
    rsp_ready = 1'b1;
    o0 = mk_req(32'h00000010, 32'h00000010, 1'b1, 5'd0, 1'b0);   // 16-16: zero flag
    o1 = mk_req(32'h80000000, 32'h80000000, 1'b0, 5'd7, 1'b0);   // add: carry out, zero
    pend0.push_back(o0); pend0.push_back(o1);
    apply();
    step();
    step();
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_zero, rsp_result} !== {2'b11, 32'h0} || alu_a !== o1.a) begin
      n_errors++; $display("FAIL dr_first: got v=%b z=%b r=%h alu_a=%h, required v=1 z=1 r=0 alu_a=%h",
                           rsp_valid, rsp_zero, rsp_result, alu_a, o1.a);
    end
    step();
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_carry, rsp_zero, rsp_sign, rsp_result} !== {4'b1110, 32'h0}) begin
      n_errors++; $display("FAIL dr_refill: got v=%b c=%b z=%b s=%b r=%h, required v=1 c=1 z=1 s=0 r=0",
                           rsp_valid, rsp_carry, rsp_zero, rsp_sign, rsp_result);
    end
    drain("drain_refill");
  endtask

  task automatic test_async_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pend0.push_back(mk_req($urandom | 32'h1, $urandom, 1'b0, OW'(4), 1'b0));
      pend1.push_back(mk_req($urandom | 32'h1, $urandom, 1'b0, OW'(5), 1'b0));
    end
    apply();
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
      n_errors++; $display("FAIL areset_valids: got rsp_v=%b rdy=%b%b, required 000", rsp_valid, req0_ready, req1_ready);
    end
    n_checks++;
    if ({alu_a, alu_b, alu_sel, alu_op} !== '0) begin
      n_errors++; $display("FAIL areset_alu: got %h/%h/%b/%h, required all 0", alu_a, alu_b, alu_sel, alu_op);
    end
    pend0.delete(); pend1.delete(); sb.delete();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    grant_log.delete(); rsp_log.delete();
    pend0.push_back(mk_req(32'h5, 32'h3, 1'b0, 5'd4, 1'b0));
    pend1.push_back(mk_req(32'h9, 32'h1, 1'b1, 5'd4, 1'b0));
    apply();
    drain("async_reset");
    n_checks++;
    if (grant_log.size() != 2 || grant_log[0] != 0) begin
      n_errors++; $display("FAIL areset_first_grant: got %0d grants first=%0d, required 2 first=0",
                           grant_log.size(), grant_log.size() ? grant_log[0] : -1);
    end
  endtask

`ifdef ALU_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    grant_log.delete();
    rsp_ready = 1'b1;
    pend0.push_back(mk_req(32'h7, 32'h7, 1'b0, 5'd3, 1'b1));
    pend0.push_back(mk_req(32'h9, 32'h2, 1'b1, 5'd3, 1'b1));
    pend0.push_back(mk_req(32'h4, 32'h1, 1'b0, 5'd4, 1'b0));
    for (int k = 0; k < 3; k++) pend1.push_back(mk_req($urandom, $urandom, 1'b0, 5'd6, 1'b0));
    apply();
    drain("lock");
    n_checks++;
    if (grant_log.size() < 4 || grant_log[0] != 0 || grant_log[1] != 0 || grant_log[2] != 0 || grant_log[3] != 1) begin
      n_errors++; $display("FAIL lock_order: got %p, required 0,0,0,1,...", grant_log);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_op();
    test_conflict();
    test_backpressure();
    test_drain_refill();
    test_async_reset();
`ifdef ALU_ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
